sd_register_set: RTL and testbench

SD_REGISTER_SET -- requirements
Module: sd_register_set

---
 rtl/sd_register_set.sv | 138 +++++++++++++
 tb/tb_sd_register_set.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_register_set.sv
// SD host register file: byte-addressed control/status registers with
// single-cycle registered access, W1C interrupt status and response capture.
module sd_register_set (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wnr,
   input  logic [7:0]  address,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        ack,
   output logic        err,
   input  logic [7:0]  int_set,
   input  logic [7:0]  status_in,
   input  logic [31:0] resp_in,
   input  logic        resp_valid,
   output logic [31:0] argument,
   output logic [5:0]  cmd_index,
   output logic        cmd_start,
   output logic [11:0] block_size,
   output logic [15:0] block_count,
   output logic [7:0]  clk_div,
   output logic        irq
);

   localparam logic [7:0]  VERSION     = 8'h10;
   localparam logic [11:0] BLKSIZE_RST = 12'h200;
   localparam logic [7:0]  CLKDIV_RST  = 8'h7F;

   logic [31:0] r_arg;
   logic [5:0]  r_cmd;
   logic [11:0] r_bsz;
   logic [15:0] r_bcnt;
   logic [7:0]  r_cdiv;
   logic [7:0]  r_ist;
   logic [7:0]  r_ien;
   logic [31:0] r_resp;
   logic [7:0]  r_dout;
   logic        r_ack;
   logic        r_err;
   logic        r_cs;
   logic        r_irq;

   logic        w_wr;
   logic        w_rd;
   logic        w_mapped;
   logic [7:0]  w_rdata;
   logic [7:0]  w_clr;

   assign w_wr  = req & wnr;
   assign w_rd  = req & ~wnr;
   assign w_clr = (w_wr && address == 8'h08) ? data_in : '0;

   // Read mux uses pre-edge register values, so a RESP read racing a capture returns old data
   always_comb begin
      w_rdata  = '0;
      w_mapped = 1'b1;
      case (address)
         8'h00:   w_rdata = r_arg[7:0];
         8'h01:   w_rdata = r_arg[15:8];
         8'h02:   w_rdata = r_arg[23:16];
         8'h03:   w_rdata = r_arg[31:24];
         8'h04:   w_rdata = {2'b00, r_cmd};
         8'h05:   w_rdata = '0;
         8'h06:   w_rdata = status_in;
         8'h08:   w_rdata = r_ist;
         8'h09:   w_rdata = r_ien;
         8'h0A:   w_rdata = r_bsz[7:0];
         8'h0B:   w_rdata = {4'h0, r_bsz[11:8]};
         8'h0C:   w_rdata = r_bcnt[7:0];
         8'h0D:   w_rdata = r_bcnt[15:8];
         8'h0E:   w_rdata = r_cdiv;
         8'h0F:   w_rdata = VERSION;
         8'h10:   w_rdata = r_resp[7:0];
         8'h11:   w_rdata = r_resp[15:8];
         8'h12:   w_rdata = r_resp[23:16];
         8'h13:   w_rdata = r_resp[31:24];
         default: w_mapped = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_arg  <= '0;
         r_cmd  <= '0;
         r_bsz  <= BLKSIZE_RST;
         r_bcnt <= '0;
         r_cdiv <= CLKDIV_RST;
         r_ist  <= '0;
         r_ien  <= '0;
         r_resp <= '0;
         r_dout <= '0;
         r_ack  <= 1'b0;
         r_err  <= 1'b0;
         r_cs   <= 1'b0;
         r_irq  <= 1'b0;
      end else begin
         r_ack <= req;
         r_err <= req & ~w_mapped;
         r_cs  <= w_wr && address == 8'h05 && data_in[0];
         r_irq <= |(r_ist & r_ien);
         if (w_rd)
            r_dout <= w_rdata;
         if (w_wr) begin
            case (address)
               8'h00:   r_arg[7:0]   <= data_in;
               8'h01:   r_arg[15:8]  <= data_in;
               8'h02:   r_arg[23:16] <= data_in;
               8'h03:   r_arg[31:24] <= data_in;
               8'h04:   r_cmd        <= data_in[5:0];
               8'h09:   r_ien        <= data_in;
               8'h0A:   r_bsz[7:0]   <= data_in;
               8'h0B:   r_bsz[11:8]  <= data_in[3:0];
               8'h0C:   r_bcnt[7:0]  <= data_in;
               8'h0D:   r_bcnt[15:8] <= data_in;
               8'h0E:   r_cdiv       <= data_in;
               default: ;
            endcase
         end
         // Set is OR'd after the clear so a coincident set wins
         r_ist <= (r_ist & ~w_clr) | int_set;
         if (resp_valid)
            r_resp <= resp_in;
      end
   end

   assign data_out    = r_dout;
   assign ack         = r_ack;
   assign err         = r_err;
   assign cmd_start   = r_cs;
   assign irq         = r_irq;
   assign argument    = r_arg;
   assign cmd_index   = r_cmd;
   assign block_size  = r_bsz;
   assign block_count = r_bcnt;
   assign clk_div     = r_cdiv;

endmodule

// File: tb/tb_sd_register_set.sv
// Testbench for sd_register_set: directed scenarios plus random traffic
// checked against a register-map model.
module tb_sd_register_set;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        wnr;
   logic [7:0]  address;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        ack;
   logic        err;
   logic [7:0]  int_set;
   logic [7:0]  status_in;
   logic [31:0] resp_in;
   logic        resp_valid;
   logic [31:0] argument;
   logic [5:0]  cmd_index;
   logic        cmd_start;
   logic [11:0] block_size;
   logic [15:0] block_count;
   logic [7:0]  clk_div;
   logic        irq;

   int errors = 0;
   int checks = 0;

   sd_register_set dut (
      .clk(clk), .reset(reset), .req(req), .wnr(wnr), .address(address),
      .data_in(data_in), .data_out(data_out), .ack(ack), .err(err),
      .int_set(int_set), .status_in(status_in), .resp_in(resp_in),
      .resp_valid(resp_valid), .argument(argument), .cmd_index(cmd_index),
      .cmd_start(cmd_start), .block_size(block_size), .block_count(block_count),
      .clk_div(clk_div), .irq(irq)
   );

   always #5 clk = ~clk;

   // Register-map model
   logic [31:0] m_arg, m_resp;
   logic [5:0]  m_cmd;
   logic [11:0] m_bsz;
   logic [15:0] m_bcnt;
   logic [7:0]  m_cdiv, m_ist, m_ien;
   logic [7:0]  e_dout;
   logic        e_ack, e_err, e_cs, e_irq;

   function automatic logic m_mapped(input logic [7:0] a);
      return (a <= 8'h13) && (a != 8'h07);
   endfunction

   function automatic logic [7:0] m_read(input logic [7:0] a, input logic [7:0] st);
      logic [7:0] v;
      v = 8'h00;
      if (a <= 8'h03)                  v = 8'(m_arg >> (8 * int'(a)));
      else if (a == 8'h04)             v = {2'b00, m_cmd};
      else if (a == 8'h06)             v = st;
      else if (a == 8'h08)             v = m_ist;
      else if (a == 8'h09)             v = m_ien;
      else if (a == 8'h0A)             v = m_bsz[7:0];
      else if (a == 8'h0B)             v = {4'h0, m_bsz[11:8]};
      else if (a == 8'h0C)             v = m_bcnt[7:0];
      else if (a == 8'h0D)             v = m_bcnt[15:8];
      else if (a == 8'h0E)             v = m_cdiv;
      else if (a == 8'h0F)             v = 8'h10;
      else if (a >= 8'h10 && a <= 8'h13) v = 8'(m_resp >> (8 * (int'(a) - 16)));
      return v;
   endfunction

   task automatic m_reset();
      m_arg = 0; m_resp = 0; m_cmd = 0; m_bsz = 12'h200; m_bcnt = 0;
      m_cdiv = 8'h7F; m_ist = 0; m_ien = 0;
      e_dout = 0; e_ack = 0; e_err = 0; e_cs = 0; e_irq = 0;
   endtask

   // Drive one cycle, advance the model at the edge, return at the following negedge
   task automatic step(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] iset, input logic rv, input logic [31:0] rin);
      logic [7:0] rdv;
      logic       nirq;
      req = r; wnr = w; address = a; data_in = d; int_set = iset;
      resp_valid = rv; resp_in = rin;
      @(posedge clk);
      rdv  = m_read(a, status_in);
      nirq = |(m_ist & m_ien);
      e_ack = r;
      e_err = r && !m_mapped(a);
      e_cs  = r && w && a == 8'h05 && d[0];
      if (r && !w) e_dout = rdv;
      if (r && w) begin
         if (a <= 8'h03) m_arg[8*int'(a) +: 8] = d;
         else if (a == 8'h04) m_cmd = d[5:0];
         else if (a == 8'h08) m_ist = m_ist & ~d;
         else if (a == 8'h09) m_ien = d;
         else if (a == 8'h0A) m_bsz[7:0] = d;
         else if (a == 8'h0B) m_bsz[11:8] = d[3:0];
         else if (a == 8'h0C) m_bcnt[7:0] = d;
         else if (a == 8'h0D) m_bcnt[15:8] = d;
         else if (a == 8'h0E) m_cdiv = d;
      end
      m_ist = m_ist | iset;
      if (rv) m_resp = rin;
      e_irq = nirq;
      @(negedge clk);
      req = 0; int_set = 0; resp_valid = 0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      step(1'b1, 1'b1, a, d, 8'h00, 1'b0, 32'h0);
   endtask

   task automatic rd(input logic [7:0] a);
      step(1'b1, 1'b0, a, 8'h00, 8'h00, 1'b0, 32'h0);
   endtask

   task automatic idle(input logic [7:0] iset);
      step(1'b0, 1'b0, 8'h00, 8'h00, iset, 1'b0, 32'h0);
   endtask

   task automatic test_reset();
      reset = 0; req = 0; wnr = 0; address = 0; data_in = 0; int_set = 0;
      status_in = 8'hA5; resp_in = 0; resp_valid = 0;
      m_reset();
      repeat (3) @(negedge clk);
      checks++; if (ack !== 1'b0 || err !== 1'b0 || cmd_start !== 1'b0 || irq !== 1'b0) begin
         errors++; $display("FAIL reset_strobes ack=%b err=%b cs=%b irq=%b want 0000", ack, err, cmd_start, irq); end
      checks++; if (data_out !== 8'h00) begin
         errors++; $display("FAIL reset_dout got %h want 00", data_out); end
      checks++; if (argument !== 32'h0 || cmd_index !== 6'h0 || block_size !== 12'h200 ||
                    block_count !== 16'h0 || clk_div !== 8'h7F) begin
         errors++; $display("FAIL reset_regs arg=%h cmd=%h bsz=%h bcnt=%h cdiv=%h", argument, cmd_index,
                            block_size, block_count, clk_div); end
      reset = 1;
   endtask

   task automatic test_defaults();
      logic [7:0] addrs [4] = '{8'h0A, 8'h0B, 8'h0E, 8'h0F};
      logic [7:0] want  [4] = '{8'h00, 8'h02, 8'h7F, 8'h10};
      for (int i = 0; i < 4; i++) begin
         rd(addrs[i]);
         checks++; if (data_out !== want[i] || ack !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL default_read a=%h got d=%h ack=%b err=%b want d=%h ack=1 err=0",
                               addrs[i], data_out, ack, err, want[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         wr(8'(i), d[i]);
         checks++; if (ack !== 1'b1) begin
            errors++; $display("FAIL b2b_ack write %0d ack=%b want 1", i, ack); end
      end
      checks++; if (argument !== 32'h44332211) begin
         errors++; $display("FAIL b2b_arg got %h want 44332211", argument); end
      for (int i = 0; i < 4; i++) begin
         rd(8'(i));
         checks++; if (data_out !== d[i] || ack !== 1'b1) begin
            errors++; $display("FAIL b2b_readback a=%0d got %h ack=%b want %h", i, data_out, ack, d[i]); end
      end
      idle(8'h00);
      checks++; if (ack !== 1'b0) begin
         errors++; $display("FAIL idle_ack got %b want 0", ack); end
   endtask

   task automatic test_cmd_start();
      wr(8'h05, 8'h01);
      checks++; if (cmd_start !== 1'b1) begin
         errors++; $display("FAIL cmd_start_pulse got %b want 1", cmd_start); end
      idle(8'h00);
      checks++; if (cmd_start !== 1'b0) begin
         errors++; $display("FAIL cmd_start_width got %b want 0", cmd_start); end
      rd(8'h05);
      checks++; if (data_out !== 8'h00) begin
         errors++; $display("FAIL ctrl_read got %h want 00", data_out); end
      wr(8'h05, 8'hFE);
      checks++; if (cmd_start !== 1'b0) begin
         errors++; $display("FAIL cmd_start_bit0_clear got %b want 0", cmd_start); end
   endtask

   task automatic test_irq();
      wr(8'h09, 8'h04);
      idle(8'h04);
      idle(8'h00);
      checks++; if (irq !== 1'b1) begin
         errors++; $display("FAIL irq_set got %b want 1", irq); end
      wr(8'h08, 8'h04);
      idle(8'h00);
      checks++; if (irq !== 1'b0) begin
         errors++; $display("FAIL irq_clear got %b want 0", irq); end
      rd(8'h08);
      checks++; if (data_out !== 8'h00) begin
         errors++; $display("FAIL int_status_clear got %h want 00", data_out); end
      idle(8'h04);
      step(1'b1, 1'b1, 8'h08, 8'h04, 8'h04, 1'b0, 32'h0);
      rd(8'h08);
      checks++; if (data_out !== 8'h04 || irq !== 1'b1) begin
         errors++; $display("FAIL set_wins got d=%h irq=%b want d=04 irq=1", data_out, irq); end
   endtask

   task automatic test_unmapped();
      wr(8'h20, 8'h55);
      checks++; if (ack !== 1'b1 || err !== 1'b1) begin
         errors++; $display("FAIL unmapped_write ack=%b err=%b want 1 1", ack, err); end
      rd(8'h20);
      checks++; if (ack !== 1'b1 || err !== 1'b1 || data_out !== 8'h00) begin
         errors++; $display("FAIL unmapped_read ack=%b err=%b d=%h want 1 1 00", ack, err, data_out); end
      checks++; if (argument !== m_arg || cmd_index !== m_cmd || block_size !== m_bsz ||
                    block_count !== m_bcnt || clk_div !== m_cdiv) begin
         errors++; $display("FAIL unmapped_side_effect arg=%h cdiv=%h want arg=%h cdiv=%h",
                            argument, clk_div, m_arg, m_cdiv); end
      rd(8'h07);
      checks++; if (err !== 1'b1 || data_out !== 8'h00) begin
         errors++; $display("FAIL hole_07 err=%b d=%h want 1 00", err, data_out); end
      rd(8'h13);
      checks++; if (err !== 1'b0) begin
         errors++; $display("FAIL last_mapped err=%b want 0", err); end
   endtask

   task automatic test_resp_race();
      step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 32'hCAFEF00D);
      step(1'b1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 32'h12345678);
      checks++; if (data_out !== 8'hFE) begin
         errors++; $display("FAIL resp_race got %h want FE", data_out); end
      rd(8'h12);
      checks++; if (data_out !== 8'h34) begin
         errors++; $display("FAIL resp_new got %h want 34", data_out); end
   endtask

   task automatic test_reset_midwrite();
      wr(8'h0E, 8'h33);
      checks++; if (clk_div !== 8'h33) begin
         errors++; $display("FAIL clkdiv_write got %h want 33", clk_div); end
      req = 1; wnr = 1; address = 8'h0E; data_in = 8'h55;
      #2 reset = 0;
      @(posedge clk); #1;
      m_reset();
      checks++; if (ack !== 1'b0 || clk_div !== 8'h7F) begin
         errors++; $display("FAIL reset_midwrite ack=%b cdiv=%h want 0 7F", ack, clk_div); end
      @(negedge clk);
      req = 0; reset = 1;
      rd(8'h0E);
      checks++; if (ack !== 1'b1 || data_out !== 8'h7F) begin
         errors++; $display("FAIL first_after_reset ack=%b d=%h want 1 7F", ack, data_out); end
   endtask

   task automatic test_random();
      logic [7:0] a;
      for (int n = 0; n < 400; n++) begin
         a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 23));
         status_in = 8'($urandom);
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), a, 8'($urandom),
              ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00,
              1'($urandom_range(0, 3) == 0), $urandom);
         checks++; if (ack !== e_ack || err !== e_err || cmd_start !== e_cs || irq !== e_irq) begin
            errors++; $display("FAIL rnd_strobes n=%0d ack/err/cs/irq=%b%b%b%b want %b%b%b%b",
                               n, ack, err, cmd_start, irq, e_ack, e_err, e_cs, e_irq); end
         checks++; if (data_out !== e_dout) begin
            errors++; $display("FAIL rnd_dout n=%0d a=%h got %h want %h", n, a, data_out, e_dout); end
         checks++; if (argument !== m_arg || cmd_index !== m_cmd || block_size !== m_bsz ||
                       block_count !== m_bcnt || clk_div !== m_cdiv) begin
            errors++; $display("FAIL rnd_regs n=%0d arg=%h cmd=%h bsz=%h bcnt=%h cdiv=%h want %h %h %h %h %h",
                               n, argument, cmd_index, block_size, block_count, clk_div,
                               m_arg, m_cmd, m_bsz, m_bcnt, m_cdiv); end
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_back_to_back();
      test_cmd_start();
      test_irq();
      test_unmapped();
      test_resp_race();
      test_reset_midwrite();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule
